// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-granular data memory.
package dmem_pkg;

    localparam int LINE_W        = 256;
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, synchronous registered read.
// The array itself is not reset; only the read register is cleared.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LINES = 512,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    // Commit a line when the controller asserts the write enable.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    // Read register holds the last line read until the next read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_line_ctrl.sv
// Request controller for the line memory: accepts one request at a time,
// waits a fixed latency, performs the access and pulses ack for one cycle.
//
// state | meaning
// IDLE  | waiting for enable_i; request latched on acceptance
// WAIT  | counting latency; access performed on the last WAIT edge
// ACK   | ack_o high for exactly this cycle
module dmem_line_ctrl
    import dmem_pkg::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 512,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ack_q;
    logic              accept;
    logic              done;
    logic              wr_en;
    logic              rd_en;
    logic              unused_addr;

    // Offset bits and bits above the index do not select a line (aliasing).
    assign unused_addr = ^{addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W],
                           addr_i[LINE_OFFSET_W-1:0]};

    assign accept = (state_q == IDLE) && enable_i;
    assign done   = (state_q == WAIT) && (cnt_q == CNT_W'(LATENCY - 1));
    assign wr_en  = done && write_q;
    assign rd_en  = done && !write_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable_i) state_d = WAIT;
            WAIT: if (done)     state_d = ACK;
            ACK:                state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Latency counter: cleared on acceptance, counts up through WAIT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Request latches; inputs are ignored outside IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            idx_q   <= addr_i[LINE_OFFSET_W +: IDX_W];
            write_q <= write_i;
            wdata_q <= data_i;
        end
    end

    // Registered acknowledge, high exactly while in ACK.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= (state_d == ACK);
        end
    end

    assign ack_o = ack_q;

    dmem_line_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (data_o)
    );

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Self-checking bench for dmem_line_ctrl against a line-array reference model.
module tb_dmem_line_ctrl;

    localparam int LAT   = 10;
    localparam int DEPTH = 512;

    logic         clk_i;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    int checks = 0;
    int errors = 0;

    logic [255:0] model [DEPTH];
    logic [255:0] last_rd;

    dmem_line_ctrl #(
        .LATENCY     (LAT),
        .DEPTH_LINES (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One request; checks ack timing, ack count and returned data, then updates the model.
    task automatic req(input string name, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wdata, input bit toggle);
        int           idx;
        int           ack_at;
        int           ack_cnt;
        logic [255:0] exp;
        idx = line_of(addr);
        exp = wr ? last_rd : model[idx];
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = wdata;
        tick();
        enable_i = 1'b0;
        ack_at   = -1;
        ack_cnt  = 0;
        for (int n = 1; n <= LAT + 4; n++) begin
            if (toggle) begin
                enable_i = (n <= LAT + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                write_i  = 1'($urandom_range(0, 1));
                addr_i   = $urandom;
                data_i   = rand_line();
            end
            tick();
            if (ack_o === 1'b1) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = n;
            end
            if (n == LAT)     check({name, " data at ack"}, data_o, exp);
            if (n == LAT + 1) check({name, " data held"}, data_o, exp);
        end
        check({name, " ack cycle"}, 256'(ack_at), 256'(LAT));
        check({name, " ack count"}, 256'(ack_cnt), 256'd1);
        if (wr) model[idx] = wdata;
        else    last_rd = model[idx];
    endtask

    initial begin
        logic [255:0] a5;
        logic [255:0] w1234;
        logic [255:0] wl;
        int           acks [$];
        int           cnt;

        a5    = {32{8'hA5}};
        w1234 = {8{32'h12345678}};
        rst_i    = 1'b0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        last_rd  = '0;

        for (int i = 0; i < DEPTH; i++) begin
            wl = (i == 3) ? a5 : rand_line();
            dut.u_array.mem[i] = wl;
            model[i] = wl;
        end

        tick();
        check("reset ack", 256'(ack_o), 256'd0);
        check("reset data", data_o, 256'd0);
        tick();
        rst_i = 1'b1;
        tick();
        check("post-reset ack", 256'(ack_o), 256'd0);
        check("post-reset data", data_o, 256'd0);

        req("read line3", 1'b0, 32'h60, '0, 1'b0);
        req("write 0x80", 1'b1, 32'h80, w1234, 1'b0);
        req("read 0x9c", 1'b0, 32'h9C, '0, 1'b0);
        check("read 0x9c value", last_rd, w1234);
        req("toggle read", 1'b0, 32'h60, '0, 1'b1);

        // enable held through ACK: a second request follows LAT+2 edges later
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h60;
        tick();
        for (int n = 1; n <= 2 * LAT + 8; n++) begin
            tick();
            if (ack_o === 1'b1) begin
                acks.push_back(n);
                check("held enable data", data_o, model[3]);
                if (acks.size() >= 2) enable_i = 1'b0;
            end
        end
        enable_i = 1'b0;
        check("held enable ack count", 256'(acks.size()), 256'd2);
        if (acks.size() >= 2) begin
            check("held first ack", 256'(acks[0]), 256'(LAT));
            check("held second ack", 256'(acks[1]), 256'(2 * LAT + 2));
        end
        last_rd = model[3];

        // reset in the middle of a write to line 7
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'hE0;
        data_i   = ~model[7];
        tick();
        enable_i = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        rst_i = 1'b0;
        #1;
        check("abort ack", 256'(ack_o), 256'd0);
        check("abort data", data_o, 256'd0);
        tick();
        tick();
        rst_i = 1'b1;
        last_rd = '0;
        cnt = 0;
        for (int n = 0; n < LAT + 6; n++) begin
            tick();
            if (ack_o === 1'b1) cnt++;
        end
        check("abort no ack", 256'(cnt), 256'd0);
        req("line7 intact", 1'b0, 32'hE0, '0, 1'b0);

        // alias: 0x4060 maps to line 3
        wl = rand_line();
        req("alias write", 1'b1, 32'h4060, wl, 1'b0);
        req("alias read", 1'b0, 32'h60, '0, 1'b0);
        check("alias value", last_rd, wl);

        for (int r = 0; r < 25; r++) begin
            req("random", 1'($urandom_range(0, 1)), $urandom, rand_line(),
                1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_line_ctrl.md
# dmem_line_ctrl

Line-granular data memory that sits directly downstream of the CPU's data cache and serves its 256-bit refill and write-back requests over the `mem_*` handshake. It models main-memory access latency with a fixed-cycle counter and accepts one outstanding request at a time. It returns a single-cycle acknowledge once the line has been read or committed.

## Interface
- `LATENCY`, 10: cycles from request acceptance to `ack_o`; legal range is ≥1.
- `DEPTH_LINES`, 512: number of 256-bit lines; must be a power of two.
- `ADDR_W`, 32: byte-address width.

- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  request valid; driven from the cache's `mem_enable_o`.
- `write_i`  in  1  1 = write line, 0 = read line; sampled only with `enable_i`.
- `addr_i`  in  ADDR_W  byte address of the line.
- `data_i`  in  256  write line data.
- `ack_o`  out  1  request complete; one-cycle pulse.
- `data_o`  out  256  read line data; valid while `ack_o`=1, held until the next read completes.

## Operation
- Line index = `addr_i[5 +: log2(DEPTH_LINES)]`.
  - `addr_i[4:0]` is ignored.
  - Bits above the index are ignored, so addresses alias modulo DEPTH_LINES×32 bytes.
- FSM states:
  - IDLE: if `enable_i`=1 at a rising edge, latch `addr_i`, `write_i` and `data_i`, clear the counter, and go to WAIT.
  - WAIT: increment the counter each edge. At the edge where the counter equals LATENCY−1:
    - read: `data_o` ← mem[idx];
    - write: mem[idx] ← latched data, `data_o` unchanged;
    - go to ACK.
  - ACK: `ack_o`=1 for this cycle only. Next edge returns to IDLE.
- `enable_i`, `addr_i`, `data_i` and `write_i` are ignored in WAIT and ACK, because the request was latched at acceptance.
- Back-to-back requests: a new request is accepted only from IDLE. Minimum spacing from one acceptance to the next is LATENCY+2 edges.
- If `enable_i` is still high in the IDLE cycle after ACK, it is treated as a new request. The cache must drop `enable_i` on seeing `ack_o`.
- Memory array contents are not reset. The bench preloads them by hierarchical access to the array.

## Timing
- Reset values: state IDLE, counter 0, `ack_o`=0, `data_o`=0.
- Request accepted at edge k → `ack_o` high from edge k+LATENCY to edge k+LATENCY+1. Read data is valid in the same window.
- `ack_o` and `data_o` are registered outputs, with no combinational path from any input.
- Write commit occurs at edge k+LATENCY. A read of the same line accepted afterwards returns the new data.
- Reset asserted mid-WAIT:
  - return immediately to IDLE with `ack_o`=0 and `data_o`=0;
  - a pending write is dropped and the array is unmodified;
  - no `ack_o` is issued for the aborted request.
- Reset asserted during ACK: `ack_o` drops immediately. The write has already committed and is not rolled back.
- Counter width is `$clog2(LATENCY+1)`. It never wraps because it is cleared on acceptance.

## Structure
- Shared package `dmem_pkg` holds:
  - state enum {IDLE, WAIT, ACK};
  - `LINE_W`=256;
  - `LINE_OFFSET_W`=5.
- Sub-module `dmem_line_array`: DEPTH_LINES×256 storage with synchronous write and synchronous read, one port, with write-enable and read-enable supplied by the FSM.
- FSM, counter and request latches live in `dmem_line_ctrl`.

## Test plan
- Reset, then preload line 3 = 256'hA5…A5; read `addr_i`=0x60 with LATENCY=10 → `ack_o` high exactly in cycle 10 after acceptance, for one cycle, with `data_o`=A5…A5.
- Write 256'h1234…  to 0x80, then read 0x9C → second `ack_o` returns 256'h1234…, and `data_o` does not change during the write's ack.
- Read 0x60 while toggling `addr_i`/`write_i`/`enable_i` during WAIT → the result is still line 3 and exactly one `ack_o` is produced.
- Hold `enable_i` high through ACK for a read of line 3 → a second request is accepted in the following IDLE cycle, and its ack arrives LATENCY+2 cycles after the first.
- Assert `rst_i`=0 at cycle 5 of a write to line 7 → no `ack_o`, `data_o`=0, and line 7 keeps its preloaded value.
- Write with DEPTH_LINES=512 to address 0x4060 → aliases to line 3, and a read of 0x60 returns the written data.
